// File: rtl/reduce_pkg.sv
// Shared types and elaboration-time helpers for the sequenced AND/OR/XOR reducer.
package reduce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of CHUNK-bit slices needed to cover WIDTH bits.
  function automatic int nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/reduce_chunk.sv
// Combinational AND/OR/XOR of one slice; masked-off bits act as the neutral element.
module reduce_chunk #(
  parameter int CHUNK = 10
) (
  input  logic [CHUNK-1:0] slice_i,
  input  logic [CHUNK-1:0] mask_i,
  output logic             and_o,
  output logic             or_o,
  output logic             xor_o
);

  assign and_o = &(slice_i | ~mask_i);
  assign or_o  = |(slice_i & mask_i);
  assign xor_o = ^(slice_i & mask_i);

endmodule

// File: rtl/reduce_seq.sv
// Sequencer that folds a latched WIDTH-bit word through a CHUNK-bit reduction
// slice, one slice per cycle, and presents AND/OR/XOR on a valid/ready port.
module reduce_seq
  import reduce_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int CHUNK = 10
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic             busy
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_w(NCHUNK);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q;
  logic             acc_and_q, acc_and_d;
  logic             acc_or_q, acc_or_d;
  logic             acc_xor_q, acc_xor_d;
  logic             out_and_q, out_and_d;
  logic             out_or_q, out_or_d;
  logic             out_xor_q, out_xor_d;

  logic [CHUNK-1:0] chunk_arr [NCHUNK];
  logic [CHUNK-1:0] mask_arr  [NCHUNK];
  logic [CHUNK-1:0] cur_slice, cur_mask;
  logic             c_and, c_or, c_xor;
  logic             last;

  // Slice/mask tables are fixed wiring; bits past WIDTH become masked zeros.
  for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      localparam int B = k * CHUNK + i;
      if (B < WIDTH) begin : g_real
        assign chunk_arr[k][i] = shadow_q[B];
        assign mask_arr[k][i]  = 1'b1;
      end else begin : g_pad
        assign chunk_arr[k][i] = 1'b0;
        assign mask_arr[k][i]  = 1'b0;
      end
    end
  end

  always_comb begin
    cur_slice = '0;
    cur_mask  = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        cur_slice = chunk_arr[k];
        cur_mask  = mask_arr[k];
      end
    end
  end

  reduce_chunk #(.CHUNK(CHUNK)) u_chunk (
    .slice_i (cur_slice),
    .mask_i  (cur_mask),
    .and_o   (c_and),
    .or_o    (c_or),
    .xor_o   (c_xor)
  );

  assign last = (cnt_q == CW'(NCHUNK - 1));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  end

  // Shadow only loads on the accepting edge, so later in_data changes are ignored.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && in_valid) shadow_q <= in_data;
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_and_d = acc_and_q;
    acc_or_d  = acc_or_q;
    acc_xor_d = acc_xor_q;
    out_and_d = out_and_q;
    out_or_d  = out_or_q;
    out_xor_d = out_xor_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_and_d = 1'b1;
          acc_or_d  = 1'b0;
          acc_xor_d = 1'b0;
          cnt_d     = '0;
        end
      end
      ST_RUN: begin
        acc_and_d = acc_and_q & c_and;
        acc_or_d  = acc_or_q | c_or;
        acc_xor_d = acc_xor_q ^ c_xor;
        if (last) begin
          cnt_d     = '0;
          out_and_d = acc_and_q & c_and;
          out_or_d  = acc_or_q | c_or;
          out_xor_d = acc_xor_q ^ c_xor;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt_q     <= '0;
      acc_and_q <= 1'b0;
      acc_or_q  <= 1'b0;
      acc_xor_q <= 1'b0;
      out_and_q <= 1'b0;
      out_or_q  <= 1'b0;
      out_xor_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_and_q <= acc_and_d;
      acc_or_q  <= acc_or_d;
      acc_xor_q <= acc_xor_d;
      out_and_q <= out_and_d;
      out_or_q  <= out_or_d;
      out_xor_q <= out_xor_d;
    end
  end

  assign out_and = out_and_q;
  assign out_or  = out_or_q;
  assign out_xor = out_xor_q;

endmodule

// File: doc/reduce_seq.md
# reduce_seq

Multi-cycle sequencer for the 100-input AND/OR/XOR reduction datapath. It accepts one wide word per valid/ready handshake and walks it through a narrow CHUNK-bit reduction slice, one slice per cycle. It then presents the three reduced bits on a valid/ready output port. It sits between a producer of wide status vectors and any consumer that can tolerate multi-cycle latency in exchange for a small, shallow reduction tree.

## Interface
- WIDTH, 100, input vector width; must be ≥ 1.
- CHUNK, 10, bits reduced per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  rising-edge clock.
- areset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is presented.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  vector to reduce.
- out_valid  out  1  result held on out_and/out_or/out_xor.
- out_ready  in  1  consumer accepts the result.
- out_and  out  1  AND of all WIDTH bits.
- out_or  out  1  OR of all WIDTH bits.
- out_xor  out  1  XOR (parity) of all WIDTH bits.
- busy  out  1  high in RUN or DONE.

## Operation
- NCHUNK = ceil(WIDTH/CHUNK). Chunk k covers bits [k*CHUNK +: CHUNK], starting with k=0 at the LSB end.
- The last chunk may be partial. Pad missing bits with 1 for the AND path and 0 for the OR/XOR paths, so padding never changes a result.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data into a shadow register, set acc_and=1, acc_or=0, acc_xor=0, set cnt=0, and go to RUN.
  - RUN: each cycle, fold chunk cnt into the accumulators (acc_and&=, acc_or|=, acc_xor^=) and increment cnt. When the cycle folds chunk NCHUNK-1, go to DONE.
  - DONE: out_valid=1 and outputs equal the accumulators. On out_ready, go to IDLE. Otherwise hold all outputs stable.
- in_ready is high only in IDLE. in_data is ignored outside the accepting edge.
- Changes on in_data after acceptance do not affect the result, because the shadow register is used.
- out_and/out_or/out_xor are registered and change only on the edge entering DONE. Outside DONE they keep their last value and carry no meaning.
- Counter width is clog2(NCHUNK), minimum 1 bit. cnt never exceeds NCHUNK-1.
- Asserting areset in any state, including mid-RUN, aborts the operation. The partial result is discarded and never presented.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_and=0, out_or=0, out_xor=0, cnt=0, accumulators cleared.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. This is 10 cycles at the defaults.
- Throughput: at most one word per NCHUNK+2 cycles when out_ready is held high (accept, NCHUNK folds, DONE, IDLE).
- DONE with out_ready=1 at entry lasts exactly one cycle. in_ready rises on the following cycle.
- in_ready, out_valid and busy are pure state decodes with no combinational path from inputs.
- NCHUNK=1 (CHUNK=WIDTH): RUN lasts one cycle and latency is 1.

## Structure
- Package reduce_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a constant function nchunk(WIDTH, CHUNK);
  - a constant function cnt_w(n).
- Sub-module reduce_chunk, parameter CHUNK, combinational. It takes a CHUNK-bit slice plus a valid-bit mask and returns the and/or/xor of the slice with padding applied.
- The sequencer holds the FSM, shadow register, counter, accumulators and output registers.

## Test plan
- Reset mid-RUN: accept a word, assert areset after cycle 4 of RUN, release it. Required: out_valid never rises, outputs are 0, in_ready=1 on the first edge after release.
- All ones: WIDTH=100, in_data all ones, out_ready=1. Required: exactly 10 cycles after acceptance, out_and=1, out_or=1, out_xor=0 (even count). in_ready returns after 12 cycles.
- Single bit: in_data=1<<99. Required: out_and=0, out_or=1, out_xor=1. This also checks that the top chunk is indexed correctly.
- Partial chunk: WIDTH=100, CHUNK=8, in_data all ones. Required: latency 13 and out_and=1, proving the AND pad is 1.
- Backpressure and data stability:
  - Hold out_ready=0 for 5 cycles in DONE. Required: outputs and out_valid are stable and in_ready=0 throughout; release is accepted on the next edge.
  - Change in_data during RUN. Required: the result matches the originally latched word.
- Random sweep: 1000 random words against a reference &/|/^ model. Also cover the parameter combinations (100,1), (100,100) and (7,3).
